// File: rtl/pipe_hazard_ctrl.sv
// Hazard, stall and forwarding control for the 5-stage RV32I pipeline.
// Shadows ID/EX, EX/MEM, MEM/WB hazard fields to drive enables, flushes and forwards.
module pipe_hazard_ctrl #(
   parameter int REG_AW   = 5,
   parameter bit FWD_EN   = 1'b1,
   parameter int BR_STAGE = 2,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_regwrite,
   input  logic              id_memread,
   input  logic              id_memop,
   input  logic              br_taken,
   input  logic              imem_ready,
   input  logic              dmem_ready,
   output logic              pc_en,
   output logic              ifid_en,
   output logic              idex_en,
   output logic              exmem_en,
   output logic              memwb_en,
   output logic              ifid_flush,
   output logic              idex_flush,
   output logic              exmem_flush,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic              use_rs1;
      logic              use_rs2;
      logic              regwrite;
      logic              memread;
      logic              memop;
   } stage_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   stage_t id_s, ex_q, mem_q, wb_q;

   logic raw_ex, raw_mem, raw_wb;
   logic dmem_stall, load_use, lu_hit;
   logic r_dmem, r_br, r_lu, r_imem;
   logic stall_inc, flush_inc;
   logic unused_ok;

   function automatic logic hit(stage_t s, logic [REG_AW-1:0] r);
      return s.valid & s.regwrite & (s.rd == r) & (r != '0);
   endfunction

   function automatic logic [1:0] fsel(stage_t m, stage_t w,
                                       logic u, logic [REG_AW-1:0] r);
      if (!FWD_EN || !u) return 2'b00;
      if (hit(m, r))     return 2'b10;
      if (hit(w, r))     return 2'b01;
      return 2'b00;
   endfunction

   always_comb begin
      id_s          = '0;
      id_s.valid    = id_valid;
      id_s.rd       = id_rd;
      id_s.rs1      = id_rs1;
      id_s.rs2      = id_rs2;
      id_s.use_rs1  = id_use_rs1;
      id_s.use_rs2  = id_use_rs2;
      id_s.regwrite = id_regwrite;
      id_s.memread  = id_memread;
      id_s.memop    = id_memop;
   end

   assign raw_ex  = (id_use_rs1 & hit(ex_q, id_rs1))
                  | (id_use_rs2 & hit(ex_q, id_rs2));
   assign raw_mem = (id_use_rs1 & hit(mem_q, id_rs1))
                  | (id_use_rs2 & hit(mem_q, id_rs2));
   assign raw_wb  = (id_use_rs1 & hit(wb_q, id_rs1))
                  | (id_use_rs2 & hit(wb_q, id_rs2));

   assign dmem_stall = mem_q.valid & mem_q.memop & ~dmem_ready;
   assign load_use   = FWD_EN ? (raw_ex & ex_q.memread)
                              : (raw_ex | raw_mem | raw_wb);
   assign lu_hit     = load_use & id_valid;

   // One-hot rule select, highest priority first
   assign r_dmem = dmem_stall;
   assign r_br   = ~dmem_stall & br_taken;
   assign r_lu   = ~dmem_stall & ~br_taken & lu_hit;
   assign r_imem = ~dmem_stall & ~br_taken & ~lu_hit & ~imem_ready;

   assign stall_inc = r_dmem | r_lu | r_imem;
   assign flush_inc = r_br;

   always_comb begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      idex_en     = 1'b1;
      exmem_en    = 1'b1;
      memwb_en    = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      unique case (1'b1)
         r_dmem: begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
         end
         r_br: begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = (BR_STAGE == 3);
         end
         r_lu: begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
         end
         r_imem: begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
         end
         default: ;
      endcase
   end

   assign fwd_a = fsel(mem_q, wb_q, ex_q.use_rs1, ex_q.rs1);
   assign fwd_b = fsel(mem_q, wb_q, ex_q.use_rs2, ex_q.rs2);

   // A stage that advances while its upstream holds takes a bubble
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_q      <= '0;
         mem_q     <= '0;
         wb_q      <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (idex_en)
            ex_q <= (idex_flush || !ifid_en) ? '0 : id_s;
         if (exmem_en)
            mem_q <= (exmem_flush || !idex_en) ? '0 : ex_q;
         if (memwb_en)
            wb_q <= (!exmem_en) ? '0 : mem_q;
         if (stall_inc && stall_cnt != '1)
            stall_cnt <= stall_cnt + CNT_ONE;
         if (flush_inc && flush_cnt != '1)
            flush_cnt <= flush_cnt + CNT_ONE;
      end
   end

   assign unused_ok = ^{wb_q.rs1, wb_q.rs2, wb_q.use_rs1,
                        wb_q.use_rs2, wb_q.memread, wb_q.memop};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a forwarding/BR_STAGE=3 instance
// and a no-forward/BR_STAGE=2 instance with 3-bit counters share stimulus.
module tb_pipe_hazard_ctrl;

   localparam logic [7:0] RUN = 8'b11111_000;
   localparam logic [7:0] LU  = 8'b00111_010;
   localparam logic [7:0] IMW = 8'b01111_100;
   localparam logic [7:0] FRZ = 8'b00000_000;
   localparam logic [7:0] BR3 = 8'b11111_111;
   localparam logic [7:0] BR2 = 8'b11111_110;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid, id_use_rs1, id_use_rs2;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic       id_regwrite, id_memread, id_memop;
   logic       br_taken, imem_ready, dmem_ready;

   wire [7:0]  ctl_a, ctl_b;
   wire [1:0]  fa_a, fb_a, fa_b, fb_b;
   wire [15:0] stall_a, flush_a;
   wire [2:0]  stall_b, flush_b;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(
      .REG_AW(5), .FWD_EN(1'b1), .BR_STAGE(3), .CNT_W(16)
   ) dut_a (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .id_rd(id_rd), .id_regwrite(id_regwrite),
      .id_memread(id_memread), .id_memop(id_memop),
      .br_taken(br_taken), .imem_ready(imem_ready),
      .dmem_ready(dmem_ready),
      .pc_en(ctl_a[7]), .ifid_en(ctl_a[6]), .idex_en(ctl_a[5]),
      .exmem_en(ctl_a[4]), .memwb_en(ctl_a[3]),
      .ifid_flush(ctl_a[2]), .idex_flush(ctl_a[1]),
      .exmem_flush(ctl_a[0]),
      .fwd_a(fa_a), .fwd_b(fb_a),
      .stall_cnt(stall_a), .flush_cnt(flush_a)
   );

   pipe_hazard_ctrl #(
      .REG_AW(5), .FWD_EN(1'b0), .BR_STAGE(2), .CNT_W(3)
   ) dut_b (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .id_rd(id_rd), .id_regwrite(id_regwrite),
      .id_memread(id_memread), .id_memop(id_memop),
      .br_taken(br_taken), .imem_ready(imem_ready),
      .dmem_ready(dmem_ready),
      .pc_en(ctl_b[7]), .ifid_en(ctl_b[6]), .idex_en(ctl_b[5]),
      .exmem_en(ctl_b[4]), .memwb_en(ctl_b[3]),
      .ifid_flush(ctl_b[2]), .idex_flush(ctl_b[1]),
      .exmem_flush(ctl_b[0]),
      .fwd_a(fa_b), .fwd_b(fb_b),
      .stall_cnt(stall_b), .flush_cnt(flush_b)
   );

   task automatic set_id(input logic v, input logic [4:0] rd, r1, r2,
                         input logic u1, u2, rw, mr, mo);
      id_valid = v; id_rd = rd; id_rs1 = r1; id_rs2 = r2;
      id_use_rs1 = u1; id_use_rs2 = u2;
      id_regwrite = rw; id_memread = mr; id_memop = mo;
   endtask

   task automatic idle();
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
      br_taken = 0; imem_ready = 1; dmem_ready = 1;
   endtask

   task automatic do_reset();
      @(negedge clk); idle(); rst = 0;
      @(negedge clk); rst = 1;
   endtask

   task automatic test_reset();
      @(negedge clk); idle(); rst = 0; #1;
      tests++;
      if (ctl_a !== RUN || ctl_b !== RUN) begin
         fails++;
         $display("FAIL rst_ctl a=%b b=%b exp=%b", ctl_a, ctl_b, RUN);
      end
      tests++;
      if ({fa_a, fb_a, fa_b, fb_b} !== 8'h00) begin
         fails++;
         $display("FAIL rst_fwd got=%b exp=0", {fa_a, fb_a, fa_b, fb_b});
      end
      tests++;
      if (stall_a !== 16'd0 || flush_a !== 16'd0) begin
         fails++;
         $display("FAIL rst_cnt s=%0d f=%0d exp=0", stall_a, flush_a);
      end
      @(negedge clk); rst = 1;
      @(negedge clk); #1;
      tests++;
      if (ctl_a !== RUN || {fa_a, fb_a} !== 4'b0000) begin
         fails++;
         $display("FAIL rst_rel ctl=%b fwd=%b exp=%b/0000",
                  ctl_a, {fa_a, fb_a}, RUN);
      end
      tests++;
      if (stall_a !== 16'd0 || flush_b !== 3'd0) begin
         fails++;
         $display("FAIL rst_rel_cnt s=%0d f=%0d exp=0", stall_a, flush_b);
      end
   endtask

   task automatic test_load_use();
      do_reset();
      @(negedge clk); set_id(1, 5, 1, 0, 1, 0, 1, 1, 1); #1;
      tests++;
      if (ctl_a !== RUN) begin
         fails++; $display("FAIL lu_issue ctl=%b exp=%b", ctl_a, RUN);
      end
      @(negedge clk); set_id(1, 6, 5, 1, 1, 1, 1, 0, 0); #1;
      tests++;
      if (ctl_a !== LU) begin
         fails++; $display("FAIL lu_stall ctl=%b exp=%b", ctl_a, LU);
      end
      @(negedge clk); #1;
      tests++;
      if (ctl_a !== RUN || stall_a !== 16'd1) begin
         fails++;
         $display("FAIL lu_resume ctl=%b s=%0d exp=%b/1", ctl_a, stall_a, RUN);
      end
      @(negedge clk); idle(); #1;
      tests++;
      if (fa_a !== 2'b01 || fb_a !== 2'b00) begin
         fails++;
         $display("FAIL lu_fwd a=%b b=%b exp=01/00", fa_a, fb_a);
      end
   endtask

   task automatic test_forward();
      do_reset();
      @(negedge clk); set_id(1, 5, 1, 2, 1, 1, 1, 0, 0);
      @(negedge clk); set_id(1, 7, 5, 5, 1, 1, 1, 0, 0); #1;
      tests++;
      if (ctl_a !== RUN) begin
         fails++; $display("FAIL fwd_nostall ctl=%b exp=%b", ctl_a, RUN);
      end
      @(negedge clk); idle(); #1;
      tests++;
      if ({fa_a, fb_a} !== 4'b1010) begin
         fails++; $display("FAIL fwd_mem got=%b exp=1010", {fa_a, fb_a});
      end
      do_reset();
      @(negedge clk); set_id(1, 0, 1, 2, 1, 1, 1, 0, 0);
      @(negedge clk); set_id(1, 7, 0, 0, 1, 1, 1, 0, 0);
      @(negedge clk); idle(); #1;
      tests++;
      if ({fa_a, fb_a} !== 4'b0000) begin
         fails++; $display("FAIL fwd_x0 got=%b exp=0000", {fa_a, fb_a});
      end
   endtask

   task automatic test_no_fwd();
      do_reset();
      @(negedge clk); set_id(1, 5, 1, 2, 1, 1, 1, 0, 0); #1;
      tests++;
      if (ctl_b !== RUN) begin
         fails++; $display("FAIL nf_issue ctl=%b exp=%b", ctl_b, RUN);
      end
      @(negedge clk); set_id(1, 7, 5, 5, 1, 1, 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         tests++;
         if (ctl_b !== LU) begin
            fails++;
            $display("FAIL nf_stall%0d ctl=%b exp=%b", i, ctl_b, LU);
         end
      end
      @(negedge clk); #1;
      tests++;
      if (ctl_b !== RUN || stall_b !== 3'd3) begin
         fails++;
         $display("FAIL nf_go ctl=%b s=%0d exp=%b/3", ctl_b, stall_b, RUN);
      end
      @(negedge clk); idle(); #1;
      tests++;
      if ({fa_b, fb_b} !== 4'b0000) begin
         fails++; $display("FAIL nf_fwd got=%b exp=0000", {fa_b, fb_b});
      end
   endtask

   task automatic test_branch();
      do_reset();
      @(negedge clk); set_id(1, 5, 1, 0, 1, 0, 1, 1, 1);
      @(negedge clk); set_id(1, 6, 5, 1, 1, 1, 1, 0, 0); br_taken = 1; #1;
      tests++;
      if (ctl_a !== BR3 || ctl_b !== BR2) begin
         fails++;
         $display("FAIL br_lu a=%b b=%b exp=%b/%b", ctl_a, ctl_b, BR3, BR2);
      end
      @(negedge clk); idle(); #1;
      tests++;
      if (flush_a !== 16'd1 || stall_a !== 16'd0 || flush_b !== 3'd1) begin
         fails++;
         $display("FAIL br_cnt f=%0d s=%0d fb=%0d exp=1/0/1",
                  flush_a, stall_a, flush_b);
      end
      tests++;
      if (ctl_a !== RUN) begin
         fails++; $display("FAIL br_after ctl=%b exp=%b", ctl_a, RUN);
      end
   endtask

   task automatic test_dmem();
      do_reset();
      @(negedge clk); set_id(1, 5, 1, 0, 1, 0, 1, 1, 1);
      @(negedge clk); idle();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); dmem_ready = 0; br_taken = 1; #1;
         tests++;
         if (ctl_a !== FRZ) begin
            fails++;
            $display("FAIL dm_frz%0d ctl=%b exp=%b", i, ctl_a, FRZ);
         end
      end
      @(negedge clk); dmem_ready = 1; #1;
      tests++;
      if (ctl_a !== BR3 || stall_a !== 16'd4 || flush_a !== 16'd0) begin
         fails++;
         $display("FAIL dm_rel ctl=%b s=%0d f=%0d exp=%b/4/0",
                  ctl_a, stall_a, flush_a, BR3);
      end
      @(negedge clk); idle(); #1;
      tests++;
      if (flush_a !== 16'd1 || stall_a !== 16'd4) begin
         fails++;
         $display("FAIL dm_cnt f=%0d s=%0d exp=1/4", flush_a, stall_a);
      end
   endtask

   task automatic test_saturate();
      do_reset();
      @(negedge clk); set_id(1, 5, 1, 0, 1, 0, 1, 1, 1);
      @(negedge clk); idle();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); dmem_ready = 0;
      end
      @(negedge clk); dmem_ready = 1; #1;
      tests++;
      if (stall_b !== 3'd7 || stall_a !== 16'd10) begin
         fails++;
         $display("FAIL sat_stall b=%0d a=%0d exp=7/10", stall_b, stall_a);
      end
      for (int i = 0; i < 9; i++) begin
         @(negedge clk); br_taken = 1;
      end
      @(negedge clk); idle(); #1;
      tests++;
      if (flush_b !== 3'd7 || flush_a !== 16'd9) begin
         fails++;
         $display("FAIL sat_flush b=%0d a=%0d exp=7/9", flush_b, flush_a);
      end
   endtask

   task automatic test_imem();
      do_reset();
      @(negedge clk); set_id(1, 5, 1, 0, 1, 0, 1, 1, 1);
      @(negedge clk); set_id(1, 6, 5, 1, 1, 1, 1, 0, 0); imem_ready = 0; #1;
      tests++;
      if (ctl_a !== LU) begin
         fails++; $display("FAIL im_lu ctl=%b exp=%b", ctl_a, LU);
      end
      @(negedge clk); #1;
      tests++;
      if (ctl_a !== IMW) begin
         fails++; $display("FAIL im_wait ctl=%b exp=%b", ctl_a, IMW);
      end
      @(negedge clk); idle(); #1;
      tests++;
      if (stall_a !== 16'd2 || ctl_a !== RUN) begin
         fails++;
         $display("FAIL im_cnt s=%0d ctl=%b exp=2/%b", stall_a, ctl_a, RUN);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      @(negedge clk); set_id(1, 5, 1, 0, 1, 0, 1, 1, 1);
      @(negedge clk); idle();
      @(negedge clk); dmem_ready = 0; #1;
      tests++;
      if (ctl_a !== FRZ) begin
         fails++; $display("FAIL rm_frz ctl=%b exp=%b", ctl_a, FRZ);
      end
      @(negedge clk); #1;
      rst = 0; #1;
      tests++;
      if (ctl_a !== RUN || stall_a !== 16'd0) begin
         fails++;
         $display("FAIL rm_async ctl=%b s=%0d exp=%b/0", ctl_a, stall_a, RUN);
      end
      @(negedge clk); rst = 1;
      @(negedge clk); #1;
      tests++;
      if (ctl_a !== RUN || stall_a !== 16'd0) begin
         fails++;
         $display("FAIL rm_resid ctl=%b s=%0d exp=%b/0", ctl_a, stall_a, RUN);
      end
      idle();
   endtask

   initial begin
      rst = 0;
      idle();
      test_reset();
      test_load_use();
      test_forward();
      test_no_fwd();
      test_branch();
      test_dmem();
      test_saturate();
      test_imem();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
